cci_mpf_pwrite_rmw: RTL and testbench
=====================================

Name: cci_mpf_pwrite_rmw

Overview:
- Read-modify-write engine at the core of the MPF partial-write path.
- Consumes byte masks forwarded from the AFU edge (wen/widx/wpartial) and stores them in a per-heap-index mask table.
- For each write reaching the engine, it either passes the write through unchanged (full-line write) or reads the current line, merges it under the mask, and drives the upd_* bundle to the FIU edge.
- Only one RMW is in flight at a time.

Parameters:
- N_WRITE_HEAP_ENTRIES, 16: write heap depth. IDX_W = $clog2(N_WRITE_HEAP_ENTRIES).
- ADDR_WIDTH, 42: cache-line address width.
- LINE_BYTES, 64: bytes per line. Data width is 8*LINE_BYTES; mask width is LINE_BYTES.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- wen  in  1  mask table write strobe from AFU edge
- widx  in  IDX_W  heap index for the mask write
- wpartial_en  in  1  write is partial
- wpartial_mask  in  LINE_BYTES  1 = byte comes from new data
- req_valid  in  1  write to process
- req_ready  out  1  engine can accept a write
- req_idx  in  IDX_W  heap index of the write
- req_addr  in  ADDR_WIDTH  line address
- req_data  in  8*LINE_BYTES  new write data
- rd_req_valid  out  1  line read request
- rd_req_ready  in  1  read channel accepts the request
- rd_req_addr  out  ADDR_WIDTH  address to read
- rd_rsp_valid  in  1  read data valid
- rd_rsp_data  in  8*LINE_BYTES  current line contents
- upd_en  out  1  one-cycle merged-data strobe
- upd_idx  out  IDX_W  heap index being updated
- upd_data  out  8*LINE_BYTES  merged line
- upd_partial_en  out  1  mirrors the table entry
- upd_partial_mask  out  LINE_BYTES  mirrors the table entry
- done_valid  out  1  one-cycle completion pulse per accepted request
- done_rmw  out  1  qualifies done_valid: 1 = an RMW was performed
- stat_rmw_cnt  out  32  saturating count of RMWs performed

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - FSM in IDLE; all mask table valid bits cleared.
  - upd_en, done_valid, done_rmw, rd_req_valid = 0.
  - stat_rmw_cnt = 0.
  - Data, address and index registers reset to 0.
  - Reset asserted mid-RMW abandons the operation: no upd_en and no done_valid are emitted. A read response arriving after reset is released is ignored in IDLE.
- Mask table:
  - Each entry holds {partial_en, mask}.
  - wen writes entry widx on the clock edge.
  - An entry is cleared when its request is accepted, except when a wen to the same index occurs in that same cycle. In that case the wen value is stored (new write wins).
- Table lookup at acceptance: a same-cycle wen with widx == req_idx bypasses the table and its value is used.
- req_ready = (state == IDLE). Acceptance is req_valid && req_ready at cycle T; idx, addr, data and entry are captured.
- Full-write path: taken when the entry has partial_en = 0, or partial_en = 1 with an all-ones mask.
  - done_valid = 1 and done_rmw = 0 at T+1.
  - No read is issued and upd_en stays 0.
  - State returns to IDLE at T+1; req_ready is high again at T+1.
- Partial path, FSM IDLE -> RD_REQ -> RD_WAIT -> UPD -> IDLE:
  - RD_REQ: rd_req_valid = 1 and rd_req_addr = captured addr, held stable until rd_req_ready. Moves to RD_WAIT on the handshake cycle.
  - RD_WAIT: on rd_rsp_valid at cycle R, register merged data. For each byte b: upd_data byte b = mask[b] ? new byte b : rsp byte b. Move to UPD.
  - UPD (cycle R+1): upd_en = 1 for exactly one cycle, with upd_idx, upd_data, upd_partial_*. done_valid = 1 and done_rmw = 1 in the same cycle. stat_rmw_cnt increments, saturating at 2^32-1. Returns to IDLE.
- rd_rsp_valid outside RD_WAIT is ignored.
- An all-zero partial mask still performs the RMW; the result is the old data.
- Minimum partial latency from accept to upd_en is 3 cycles (rd_req_ready high at T+1, response at T+2).

Decomposition:
- Package cci_mpf_pwrite_rmw_pkg:
  - t_pwrite_mask_entry struct {partial_en, mask}
  - FSM state enum
  - merge function (per-byte mux)
- One sub-module: cci_mpf_pwrite_mask_table. Register array with write port, read port with same-cycle bypass, clear-on-consume, and async active-low reset of the valid bits.

Test Plan:
- Full write: wen idx 3, partial_en=0; request idx 3 -> done_valid=1, done_rmw=0 one cycle after accept; no rd_req_valid; upd_en stays 0.
- Partial merge: mask 64'h0000_0000_0000_00FF, req_data all 8'hAA, rd_rsp_data all 8'h55 -> upd_data bytes 0-7 = AA and bytes 8-63 = 55; upd_en one cycle after the response; stat_rmw_cnt=1.
- Backpressure: rd_req_ready low for 5 cycles -> rd_req_valid and rd_req_addr held stable; req_ready=0 throughout; no upd_en before the response.
- Same-cycle bypass: wen idx 2, mask all-ones, partial_en=1 in the accept cycle of req idx 2 -> full path taken; the table entry for idx 2 still holds the wen value afterwards.
- Reset mid-op: assert reset_n=0 in RD_WAIT, release, then drive rd_rsp_valid -> no upd_en, no done_valid; mask table cleared; req_ready=1.
- Back-to-back: two partial requests (idx 0, idx 1) with one-cycle read response -> second accepted one cycle after the first UPD; upd_idx sequence 0 then 1; stat_rmw_cnt=2.

Source files
------------

// File: rtl/cci_mpf_pwrite_rmw_pkg.sv
// Shared types and helpers for the MPF partial-write read-modify-write engine.
// The mask-entry struct and merge helper are sized by PWRITE_LINE_BYTES.
// Instantiate the engine with LINE_BYTES equal to this value.
package cci_mpf_pwrite_rmw_pkg;

    localparam int PWRITE_LINE_BYTES = 64;
    localparam int PWRITE_DATA_W     = 8 * PWRITE_LINE_BYTES;

    // One mask table entry: whether the write is partial, and which bytes are new.
    typedef struct packed {
        logic                         partial_en;
        logic [PWRITE_LINE_BYTES-1:0] mask;
    } t_pwrite_mask_entry;

    // RMW sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_UPD     = 2'd3
    } t_rmw_state;

    // Byte-wise merge: a set mask bit takes the new byte, a clear bit keeps the old byte.
    function automatic logic [PWRITE_DATA_W-1:0] pwrite_merge(
        input logic [PWRITE_DATA_W-1:0]     new_data,
        input logic [PWRITE_DATA_W-1:0]     old_data,
        input logic [PWRITE_LINE_BYTES-1:0] mask
    );
        logic [PWRITE_DATA_W-1:0] res;
        res = old_data;
        for (int b = 0; b < PWRITE_LINE_BYTES; b++) begin
            if (mask[b]) begin
                res[b*8 +: 8] = new_data[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_data[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cci_mpf_pwrite_mask_table.sv
// Per-heap-index byte-mask table.
// Writes come from the AFU edge. Lookup has a same-cycle write bypass.
// An entry is invalidated when its request is consumed. A write to the same
// index in that same cycle overrides the clear.
module cci_mpf_pwrite_mask_table
    import cci_mpf_pwrite_rmw_pkg::*;
#(
    parameter int N_ENTRIES  = 16,
    parameter int LINE_BYTES = PWRITE_LINE_BYTES,
    localparam int IDX_W     = $clog2(N_ENTRIES)
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wen,
    input  logic [IDX_W-1:0]      widx,
    input  logic                  wpartial_en,
    input  logic [LINE_BYTES-1:0] wpartial_mask,
    input  logic [IDX_W-1:0]      lookup_idx,
    output logic                  lookup_partial_en,
    output logic [LINE_BYTES-1:0] lookup_mask,
    input  logic                  clr_en,
    input  logic [IDX_W-1:0]      clr_idx
);

    t_pwrite_mask_entry entry_r [N_ENTRIES];
    logic [N_ENTRIES-1:0] valid_r;
    t_pwrite_mask_entry   wr_entry_s;
    t_pwrite_mask_entry   rd_entry_s;

    // Pack the incoming write into the stored entry format.
    always_comb begin
        wr_entry_s            = '0;
        wr_entry_s.partial_en = wpartial_en;
        wr_entry_s.mask       = wpartial_mask;
    end

    // Table storage: a clear is applied first so that a same-cycle write to the same index wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                entry_r[i] <= '0;
            end
        end else begin
            if (clr_en) begin
                valid_r[clr_idx] <= 1'b0;
            end
            if (wen) begin
                valid_r[widx] <= 1'b1;
                entry_r[widx] <= wr_entry_s;
            end
        end
    end

    // Lookup: a same-cycle write bypasses storage. An invalid entry reads as a full write.
    always_comb begin
        rd_entry_s = '0;
        if (wen && (widx == lookup_idx)) begin
            rd_entry_s = wr_entry_s;
        end else if (valid_r[lookup_idx]) begin
            rd_entry_s = entry_r[lookup_idx];
        end else begin
            rd_entry_s = '0;
        end
    end

    assign lookup_partial_en = rd_entry_s.partial_en;
    assign lookup_mask       = rd_entry_s.mask;

endmodule

// File: rtl/cci_mpf_pwrite_rmw.sv
// Partial-write read-modify-write engine.
// Full-line writes complete one cycle after acceptance without a read.
// Partial writes read the current line and merge it under the stored byte mask.
// The merged line is presented on the upd_* bundle. Only one RMW is in flight.
module cci_mpf_pwrite_rmw
    import cci_mpf_pwrite_rmw_pkg::*;
#(
    parameter int N_WRITE_HEAP_ENTRIES = 16,
    parameter int ADDR_WIDTH           = 42,
    parameter int LINE_BYTES           = PWRITE_LINE_BYTES,
    localparam int IDX_W               = $clog2(N_WRITE_HEAP_ENTRIES),
    localparam int DATA_W              = 8 * LINE_BYTES
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wen,
    input  logic [IDX_W-1:0]      widx,
    input  logic                  wpartial_en,
    input  logic [LINE_BYTES-1:0] wpartial_mask,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [IDX_W-1:0]      req_idx,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_data,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [ADDR_WIDTH-1:0] rd_req_addr,
    input  logic                  rd_rsp_valid,
    input  logic [DATA_W-1:0]     rd_rsp_data,
    output logic                  upd_en,
    output logic [IDX_W-1:0]      upd_idx,
    output logic [DATA_W-1:0]     upd_data,
    output logic                  upd_partial_en,
    output logic [LINE_BYTES-1:0] upd_partial_mask,
    output logic                  done_valid,
    output logic                  done_rmw,
    output logic [31:0]           stat_rmw_cnt
);

    t_rmw_state state_r;
    t_rmw_state state_nxt_s;

    logic                  accept_s;
    logic                  full_s;
    logic                  rsp_take_s;
    logic                  lk_partial_en_s;
    logic [LINE_BYTES-1:0] lk_mask_s;
    logic                  req_ready_s;
    logic                  rd_req_valid_s;

    logic [IDX_W-1:0]      idx_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_W-1:0]     data_r;
    logic                  partial_en_r;
    logic [LINE_BYTES-1:0] mask_r;

    logic                  upd_en_r;
    logic [DATA_W-1:0]     upd_data_r;
    logic                  done_valid_r;
    logic                  done_rmw_r;
    logic [31:0]           stat_rmw_cnt_r;

    cci_mpf_pwrite_mask_table #(
        .N_ENTRIES  (N_WRITE_HEAP_ENTRIES),
        .LINE_BYTES (LINE_BYTES)
    ) mask_table (
        .clk               (clk),
        .reset_n           (reset_n),
        .wen               (wen),
        .widx              (widx),
        .wpartial_en       (wpartial_en),
        .wpartial_mask     (wpartial_mask),
        .lookup_idx        (req_idx),
        .lookup_partial_en (lk_partial_en_s),
        .lookup_mask       (lk_mask_s),
        .clr_en            (accept_s),
        .clr_idx           (req_idx)
    );

    // Acceptance, response capture and full-versus-partial classification of the looked-up entry.
    always_comb begin
        accept_s   = req_valid && (state_r == ST_IDLE);
        rsp_take_s = rd_rsp_valid && (state_r == ST_RD_WAIT);
        if (lk_partial_en_s && !(&lk_mask_s)) begin
            full_s = 1'b0;
        end else begin
            full_s = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !full_s) begin
                    state_nxt_s = ST_RD_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (rd_req_ready) begin
                    state_nxt_s = ST_RD_WAIT;
                end else begin
                    state_nxt_s = ST_RD_REQ;
                end
            end
            ST_RD_WAIT: begin
                if (rd_rsp_valid) begin
                    state_nxt_s = ST_UPD;
                end else begin
                    state_nxt_s = ST_RD_WAIT;
                end
            end
            ST_UPD: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: handshake signals follow directly from the registered state.
    always_comb begin
        req_ready_s    = 1'b0;
        rd_req_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_ready_s = 1'b1;
            end
            ST_RD_REQ: begin
                rd_req_valid_s = 1'b1;
            end
            ST_RD_WAIT: begin
                req_ready_s = 1'b0;
            end
            ST_UPD: begin
                req_ready_s = 1'b0;
            end
            default: begin
                req_ready_s = 1'b0;
            end
        endcase
    end

    // Capture the accepted request and its mask entry. They stay stable until the engine is idle again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_r        <= '0;
            addr_r       <= '0;
            data_r       <= '0;
            partial_en_r <= 1'b0;
            mask_r       <= '0;
        end else if (accept_s) begin
            idx_r        <= req_idx;
            addr_r       <= req_addr;
            data_r       <= req_data;
            partial_en_r <= lk_partial_en_s;
            mask_r       <= lk_mask_s;
        end
    end

    // Registered strobes, merged data and the saturating RMW counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upd_en_r       <= 1'b0;
            upd_data_r     <= '0;
            done_valid_r   <= 1'b0;
            done_rmw_r     <= 1'b0;
            stat_rmw_cnt_r <= 32'd0;
        end else begin
            upd_en_r     <= rsp_take_s;
            done_valid_r <= (accept_s && full_s) || rsp_take_s;
            done_rmw_r   <= rsp_take_s;
            if (rsp_take_s) begin
                upd_data_r <= pwrite_merge(data_r, rd_rsp_data, mask_r);
            end
            if (rsp_take_s && (stat_rmw_cnt_r != 32'hFFFF_FFFF)) begin
                stat_rmw_cnt_r <= stat_rmw_cnt_r + 32'd1;
            end
        end
    end

    assign req_ready        = req_ready_s;
    assign rd_req_valid     = rd_req_valid_s;
    assign rd_req_addr      = addr_r;
    assign upd_en           = upd_en_r;
    assign upd_idx          = idx_r;
    assign upd_data         = upd_data_r;
    assign upd_partial_en   = partial_en_r;
    assign upd_partial_mask = mask_r;
    assign done_valid       = done_valid_r;
    assign done_rmw         = done_rmw_r;
    assign stat_rmw_cnt     = stat_rmw_cnt_r;

endmodule

// File: tb/tb_cci_mpf_pwrite_rmw.sv
// Directed, scoreboard-based bench for the partial-write RMW engine.
module tb_cci_mpf_pwrite_rmw;

    localparam int IDX_W = 4;
    localparam int AW    = 42;
    localparam int LB    = 64;
    localparam int DW    = 512;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            wen = 1'b0;
    logic [IDX_W-1:0] widx = '0;
    logic            wpartial_en = 1'b0;
    logic [LB-1:0]   wpartial_mask = '0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [IDX_W-1:0] req_idx = '0;
    logic [AW-1:0]   req_addr = '0;
    logic [DW-1:0]   req_data = '0;
    logic            rd_req_valid;
    logic            rd_req_ready = 1'b0;
    logic [AW-1:0]   rd_req_addr;
    logic            rd_rsp_valid = 1'b0;
    logic [DW-1:0]   rd_rsp_data = '0;
    logic            upd_en;
    logic [IDX_W-1:0] upd_idx;
    logic [DW-1:0]   upd_data;
    logic            upd_partial_en;
    logic [LB-1:0]   upd_partial_mask;
    logic            done_valid;
    logic            done_rmw;
    logic [31:0]     stat_rmw_cnt;

    cci_mpf_pwrite_rmw dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .wen              (wen),
        .widx             (widx),
        .wpartial_en      (wpartial_en),
        .wpartial_mask    (wpartial_mask),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_idx          (req_idx),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .rd_req_valid     (rd_req_valid),
        .rd_req_ready     (rd_req_ready),
        .rd_req_addr      (rd_req_addr),
        .rd_rsp_valid     (rd_rsp_valid),
        .rd_rsp_data      (rd_rsp_data),
        .upd_en           (upd_en),
        .upd_idx          (upd_idx),
        .upd_data         (upd_data),
        .upd_partial_en   (upd_partial_en),
        .upd_partial_mask (upd_partial_mask),
        .done_valid       (done_valid),
        .done_rmw         (done_rmw),
        .stat_rmw_cnt     (stat_rmw_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [DW-1:0]    data;
        logic             pen;
        logic [LB-1:0]    mask;
    } exp_upd_t;

    exp_upd_t upd_q[$];
    logic     done_q[$];
    int       checks = 0;
    int       errors = 0;
    int       upd_seen = 0;
    int       done_seen = 0;
    int       upd_exp_total = 0;
    int       done_exp_total = 0;
    logic [31:0] exp_stat = 32'd0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_merge(input logic [DW-1:0] nd, input logic [DW-1:0] od,
                                                  input logic [LB-1:0] m);
        logic [DW-1:0] bm;
        bm = '0;
        for (int b = 0; b < LB; b++) bm[b*8 +: 8] = {8{m[b]}};
        return (nd & bm) | (od & ~bm);
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        v = '0;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Advance one clock, sample #1 after the edge, and score any upd/done outputs.
    task automatic tick();
        exp_upd_t e;
        logic     d;
        @(posedge clk);
        #1;
        if (upd_en === 1'b1) begin
            upd_seen++;
            if (upd_q.size() == 0) begin
                chk("upd_spurious", DW'(upd_en), DW'(1'b0));
            end else begin
                e = upd_q.pop_front();
                chk("upd_idx", DW'(upd_idx), DW'(e.idx));
                chk("upd_data", upd_data, e.data);
                chk("upd_partial_en", DW'(upd_partial_en), DW'(e.pen));
                chk("upd_partial_mask", DW'(upd_partial_mask), DW'(e.mask));
            end
        end
        if (done_valid === 1'b1) begin
            done_seen++;
            if (done_q.size() == 0) begin
                chk("done_spurious", DW'(done_valid), DW'(1'b0));
            end else begin
                d = done_q.pop_front();
                chk("done_rmw", DW'(done_rmw), DW'(d));
            end
        end
    endtask

    task automatic write_mask(input logic [IDX_W-1:0] idx, input logic pen, input logic [LB-1:0] m);
        wen = 1'b1; widx = idx; wpartial_en = pen; wpartial_mask = m;
        tick();
        wen = 1'b0; wpartial_en = 1'b0; wpartial_mask = '0;
    endtask

    // Drive one request for a single cycle, optionally with a same-cycle mask write to its index.
    task automatic send_req(input logic [IDX_W-1:0] idx, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic byp, input logic bpen, input logic [LB-1:0] bmask);
        chk("req_ready_pre", DW'(req_ready), DW'(1'b1));
        req_valid = 1'b1; req_idx = idx; req_addr = addr; req_data = data;
        if (byp) begin
            wen = 1'b1; widx = idx; wpartial_en = bpen; wpartial_mask = bmask;
        end
        tick();
        req_valid = 1'b0; wen = 1'b0; wpartial_en = 1'b0; wpartial_mask = '0;
    endtask

    task automatic do_full(input logic [IDX_W-1:0] idx, input logic [AW-1:0] addr,
                           input logic byp, input logic bpen, input logic [LB-1:0] bmask);
        done_q.push_back(1'b0); done_exp_total++;
        send_req(idx, addr, rand_line(), byp, bpen, bmask);
        chk("full_done_valid", DW'(done_valid), DW'(1'b1));
        chk("full_no_rd_req", DW'(rd_req_valid), DW'(1'b0));
        chk("full_no_upd", DW'(upd_en), DW'(1'b0));
        chk("full_ready_again", DW'(req_ready), DW'(1'b1));
    endtask

    // Partial RMW; returns in the UPD cycle.
    task automatic do_partial(input logic [IDX_W-1:0] idx, input logic [AW-1:0] addr,
                              input logic [DW-1:0] nd, input logic [DW-1:0] rsp,
                              input logic [LB-1:0] m, input int delay,
                              input logic byp, input logic [LB-1:0] bmask);
        exp_upd_t e;
        e.idx = idx; e.data = model_merge(nd, rsp, m); e.pen = 1'b1; e.mask = m;
        upd_q.push_back(e); upd_exp_total++;
        done_q.push_back(1'b1); done_exp_total++;
        send_req(idx, addr, nd, byp, 1'b1, bmask);
        chk("rd_req_valid", DW'(rd_req_valid), DW'(1'b1));
        chk("rd_req_addr", DW'(rd_req_addr), DW'(addr));
        chk("req_ready_busy", DW'(req_ready), DW'(1'b0));
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("bp_rd_req_valid", DW'(rd_req_valid), DW'(1'b1));
            chk("bp_rd_req_addr", DW'(rd_req_addr), DW'(addr));
            chk("bp_req_ready", DW'(req_ready), DW'(1'b0));
            chk("bp_no_upd", DW'(upd_en), DW'(1'b0));
        end
        rd_req_ready = 1'b1;
        tick();
        rd_req_ready = 1'b0;
        chk("wait_rd_req_drop", DW'(rd_req_valid), DW'(1'b0));
        chk("wait_no_upd", DW'(upd_en), DW'(1'b0));
        rd_rsp_valid = 1'b1; rd_rsp_data = rsp;
        tick();
        rd_rsp_valid = 1'b0; rd_rsp_data = '0;
        exp_stat = exp_stat + 32'd1;
        chk("upd_en_after_rsp", DW'(upd_en), DW'(1'b1));
        chk("done_with_upd", DW'(done_valid), DW'(1'b1));
        chk("upd_req_ready", DW'(req_ready), DW'(1'b0));
        chk("stat_rmw_cnt", DW'(stat_rmw_cnt), DW'(exp_stat));
    endtask

    initial begin
        logic [DW-1:0] aa;
        logic [DW-1:0] ff55;
        logic [LB-1:0] ones;
        aa   = {LB{8'hAA}};
        ff55 = {LB{8'h55}};
        ones = '1;

        // Reset values
        tick(); tick();
        chk("rst_req_ready", DW'(req_ready), DW'(1'b1));
        chk("rst_upd_en", DW'(upd_en), DW'(1'b0));
        chk("rst_done_valid", DW'(done_valid), DW'(1'b0));
        chk("rst_done_rmw", DW'(done_rmw), DW'(1'b0));
        chk("rst_rd_req_valid", DW'(rd_req_valid), DW'(1'b0));
        chk("rst_stat", DW'(stat_rmw_cnt), DW'(32'd0));
        reset_n = 1'b1;
        tick();

        // Full write, partial_en = 0
        write_mask(4'd3, 1'b0, 64'h0000_0000_0000_1234);
        do_full(4'd3, 42'h000_0000_1000, 1'b0, 1'b0, '0);
        chk("stat_after_full", DW'(stat_rmw_cnt), DW'(32'd0));
        // Full write, partial_en = 1 with all-ones mask; unwritten index
        write_mask(4'd9, 1'b1, ones);
        do_full(4'd9, 42'h000_0000_2000, 1'b0, 1'b0, '0);
        do_full(4'd11, 42'h000_0000_2040, 1'b0, 1'b0, '0);

        // Partial merge, minimum latency
        write_mask(4'd6, 1'b1, 64'h0000_0000_0000_00FF);
        do_partial(4'd6, 42'h123_4567_89AB, aa, ff55, 64'h0000_0000_0000_00FF, 0, 1'b0, '0);
        chk("merge_low_bytes", DW'(upd_data[63:0]), DW'(64'hAAAA_AAAA_AAAA_AAAA));
        chk("merge_high_bytes", DW'(upd_data[DW-1:64]), DW'({(LB-8){8'h55}}));
        tick();

        // Backpressure on the read request
        write_mask(4'd8, 1'b1, 64'h8000_0000_F0F0_0001);
        do_partial(4'd8, 42'h3FF_FFFF_FFC0, rand_line(), rand_line(), 64'h8000_0000_F0F0_0001, 5, 1'b0, '0);
        tick();

        // All-zero partial mask still does the RMW and returns the old data
        write_mask(4'd10, 1'b1, 64'h0);
        do_partial(4'd10, 42'h000_0000_0440, aa, ff55, 64'h0, 1, 1'b0, '0);
        tick();

        // Same-cycle bypass with all-ones mask: full path
        do_full(4'd2, 42'h000_0000_3000, 1'b1, 1'b1, ones);
        do_full(4'd2, 42'h000_0000_3040, 1'b0, 1'b0, '0);
        // Bypass with a partial mask; the stored value survives the same-cycle clear, then is consumed
        do_partial(4'd4, 42'h000_0000_5000, rand_line(), rand_line(), 64'h0F0F, 0, 1'b1, 64'h0F0F);
        tick();
        do_partial(4'd4, 42'h000_0000_5040, rand_line(), rand_line(), 64'h0F0F, 0, 1'b0, '0);
        tick();
        do_full(4'd4, 42'h000_0000_5080, 1'b0, 1'b0, '0);

        // Reset mid-RMW, in RD_WAIT
        write_mask(4'd5, 1'b1, 64'hF0);
        write_mask(4'd7, 1'b1, 64'h0F);
        send_req(4'd5, 42'h000_0000_6000, aa, 1'b0, 1'b0, '0);
        chk("rst_op_rd_req", DW'(rd_req_valid), DW'(1'b1));
        rd_req_ready = 1'b1;
        tick();
        rd_req_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_req_ready", DW'(req_ready), DW'(1'b1));
        chk("midrst_stat", DW'(stat_rmw_cnt), DW'(32'd0));
        tick(); tick();
        reset_n = 1'b1;
        exp_stat = 32'd0;
        rd_rsp_valid = 1'b1; rd_rsp_data = ff55;
        tick();
        rd_rsp_valid = 1'b0;
        chk("postrst_no_upd", DW'(upd_en), DW'(1'b0));
        chk("postrst_no_done", DW'(done_valid), DW'(1'b0));
        chk("postrst_req_ready", DW'(req_ready), DW'(1'b1));
        tick();
        chk("postrst_no_upd2", DW'(upd_en), DW'(1'b0));
        chk("postrst_no_done2", DW'(done_valid), DW'(1'b0));
        do_full(4'd7, 42'h000_0000_7000, 1'b0, 1'b0, '0);
        do_full(4'd5, 42'h000_0000_7040, 1'b0, 1'b0, '0);

        // Back-to-back partial requests, one-cycle read response
        write_mask(4'd0, 1'b1, 64'h00FF_00FF_00FF_00FF);
        write_mask(4'd1, 1'b1, 64'hFF00_0000_0000_0003);
        do_partial(4'd0, 42'h000_0000_8000, rand_line(), rand_line(), 64'h00FF_00FF_00FF_00FF, 0, 1'b0, '0);
        tick();
        do_partial(4'd1, 42'h000_0000_8040, rand_line(), rand_line(), 64'hFF00_0000_0000_0003, 0, 1'b0, '0);
        chk("b2b_stat", DW'(stat_rmw_cnt), DW'(32'd2));
        tick();
        tick();

        // Final accounting
        chk("upd_count", DW'(upd_seen), DW'(upd_exp_total));
        chk("done_count", DW'(done_seen), DW'(done_exp_total));
        chk("upd_q_drained", DW'(upd_q.size()), DW'(0));
        chk("done_q_drained", DW'(done_q.size()), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
